// File: rtl/mc_arb_fifo.sv
// Round-robin aggregator of NUM_CH valid/ready producers into one shared FWFT FIFO (data + channel tag); MCAF_AFULL_EN adds o_afull/AF_LEVEL.
// Latency: a word accepted at edge N is at the head after edge N; o_afull lags o_level by one cycle.
// Backpressure: ch_ready is withheld while full, flushing or in reset; a pop in the same cycle does not reopen it.

module mcaf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_dat,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_dat,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_dat     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full && !i_flush && !rst;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end
endmodule

module mc_arb_fifo #(
    parameter int NUM_CH    = 4,
    parameter int D_WIDTH   = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 8
`ifdef MCAF_AFULL_EN
    , parameter int AF_LEVEL = DEPTH - 2
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH-1:0]               ch_valid,
    input  logic [NUM_CH*D_WIDTH-1:0]       ch_data,
    output logic [NUM_CH-1:0]               ch_ready,
    input  logic                            i_pop,
    input  logic                            i_flush,
    output logic                            o_valid,
    output logic [D_WIDTH-1:0]              o_data,
    output logic [$clog2(NUM_CH)-1:0]       o_chan,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [$clog2(DEPTH):0]          o_level,
    output logic [NUM_CH*CNT_WIDTH-1:0]     ch_count,
    output logic                            pop_err
`ifdef MCAF_AFULL_EN
    , output logic                          o_afull
`endif
);
    localparam int CW = $clog2(NUM_CH);

    typedef struct packed {
        logic [CW-1:0]      chan;
        logic [D_WIDTH-1:0] dat;
    } entry_t;

    entry_t                 w_wr_ent;
    entry_t                 w_rd_ent;
    logic [CW-1:0]          r_rr_ptr;
    logic [CW-1:0]          w_grant_idx;
    logic [D_WIDTH-1:0]     w_grant_dat;
    logic                   w_found;
    logic                   w_arb_en;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_level;
    logic [CNT_WIDTH-1:0]   r_cnt [NUM_CH];
    logic                   r_pop_err;
    int                     w_idx;

    // First requester at or after r_rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_grant_dat = '0;
        w_idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
            if (!w_found && ch_valid[w_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = CW'(w_idx);
                w_grant_dat = ch_data[w_idx*D_WIDTH +: D_WIDTH];
            end
        end
    end

    assign w_arb_en      = !w_full && !i_flush && !rst;
    assign w_push        = w_found && w_arb_en;
    assign ch_ready      = w_push ? (NUM_CH'(1) << w_grant_idx) : '0;
    assign w_wr_ent.chan = w_grant_idx;
    assign w_wr_ent.dat  = w_grant_dat;

    mcaf_fifo #(
        .WIDTH (CW + D_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   (w_wr_ent),
        .i_pop   (i_pop),
        .i_flush (i_flush),
        .o_dat   (w_rd_ent),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign o_valid = !w_empty;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_level = w_level;
    assign o_data  = w_rd_ent.dat;
    assign o_chan  = w_rd_ent.chan;
    assign pop_err = r_pop_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_pop_err <= 1'b0;
        end else begin
            if (w_push) r_rr_ptr <= (w_grant_idx == CW'(NUM_CH - 1)) ? '0 : w_grant_idx + CW'(1);
            if (i_pop && w_empty && !i_flush) r_pop_err <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt[g] <= '0;
            end else if (ch_ready[g] && ch_valid[g] && (r_cnt[g] != '1)) begin
                r_cnt[g] <= r_cnt[g] + 1'b1;
            end
        end
        assign ch_count[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
    end

`ifdef MCAF_AFULL_EN
    logic r_afull;
    always_ff @(posedge clk) begin
        if (rst) r_afull <= 1'b0;
        else     r_afull <= (int'(w_level) >= AF_LEVEL);
    end
    assign o_afull = r_afull;
`endif
endmodule

// File: tb/tb_mc_arb_fifo.sv
// Bench for mc_arb_fifo: hand-computed vector table, directed corner sequences and a random run against a queue-based model.
module tb_mc_arb_fifo;
    localparam int NCH   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CNTW  = 8;
    localparam int CMAX  = (1 << CNTW) - 1;
    localparam int AF    = DEPTH - 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_ready;
    logic              i_pop, i_flush;
    logic              o_valid, o_full, o_empty, pop_err;
    logic [DW-1:0]     o_data;
    logic [1:0]        o_chan;
    logic [4:0]        o_level;
    logic [NCH*CNTW-1:0] ch_count;
    logic              o_afull;

    always #5 clk = ~clk;

    mc_arb_fifo dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .i_pop(i_pop), .i_flush(i_flush), .o_valid(o_valid), .o_data(o_data), .o_chan(o_chan),
        .o_full(o_full), .o_empty(o_empty), .o_level(o_level), .ch_count(ch_count),
        .pop_err(pop_err)
`ifdef MCAF_AFULL_EN
        , .o_afull(o_afull)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an ordered list of words plus a few scalars.
    typedef struct { int ch; int dat; } ent_t;
    ent_t q[$];
    int   m_rr;
    int   m_cnt [NCH];
    bit   m_err;
    bit   m_afull;

    logic [NCH-1:0]    cur_v;
    logic [NCH*DW-1:0] cur_d;
    logic              cur_pop, cur_fl;
    int                cur_g;

    function automatic int model_grant(input logic [NCH-1:0] v, input logic fl);
        int c;
        if (fl || q.size() == DEPTH) return -1;
        for (int k = 0; k < NCH; k++) begin
            c = (m_rr + k) % NCH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rr = 0; m_err = 0; m_afull = 0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; ch_valid = '1; ch_data = $urandom; i_pop = 1'b0; i_flush = 1'b0;
        #2;
        chk("rst_ready", ch_ready, '0);
        @(posedge clk); #1;
        rst = 1'b0; ch_valid = '0;
        model_reset();
        #1;
        chk("rst_level", o_level, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_poperr", pop_err, 0);
        chk("rst_count", ch_count, '0);
`ifdef MCAF_AFULL_EN
        chk("rst_afull", o_afull, 0);
`endif
    endtask

    // Drive one cycle of inputs, then compare everything the model predicts before the edge.
    task automatic drive_and_check(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                                   input logic pop, input logic fl);
        ch_valid = v; ch_data = d; i_pop = pop; i_flush = fl;
        #2;
        cur_v = v; cur_d = d; cur_pop = pop; cur_fl = fl;
        cur_g = model_grant(v, fl);
        chk("ready", ch_ready, (cur_g >= 0) ? (64'd1 << cur_g) : 64'd0);
        chk("level", o_level, q.size());
        chk("full", o_full, q.size() == DEPTH);
        chk("empty", o_empty, q.size() == 0);
        chk("valid", o_valid, q.size() != 0);
        chk("pop_err", pop_err, m_err);
        if (q.size() != 0) begin
            chk("head_chan", o_chan, q[0].ch);
            chk("head_data", o_data, q[0].dat);
        end
        for (int i = 0; i < NCH; i++) chk("count", ch_count[i*CNTW +: CNTW], m_cnt[i]);
`ifdef MCAF_AFULL_EN
        chk("afull", o_afull, m_afull);
`endif
    endtask

    task automatic commit();
        ent_t e;
        m_afull = (q.size() >= AF);
        if (cur_fl) begin
            q.delete();
        end else begin
            if (cur_pop) begin
                if (q.size() > 0) e = q.pop_front();
                else m_err = 1;
            end
            if (cur_g >= 0) begin
                e.ch  = cur_g;
                e.dat = int'(cur_d[cur_g*DW +: DW]);
                q.push_back(e);
                if (m_cnt[cur_g] < CMAX) m_cnt[cur_g]++;
                m_rr = (cur_g + 1) % NCH;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic step(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                        input logic pop, input logic fl);
        drive_and_check(v, d, pop, fl);
        commit();
    endtask

    typedef struct {
        logic [NCH-1:0]    v;
        logic [NCH*DW-1:0] d;
        logic              pop;
        logic              fl;
        logic [NCH-1:0]    exp_ready;
        int                exp_level;
        int                exp_chan;
        int                exp_data;
        logic              exp_err;
    } vec_t;

    vec_t tbl [13];
    localparam logic [31:0] DPAT = 32'h43322110;

    initial begin
        tbl[0]  = '{4'b0100, 32'h43AA2110, 0, 0, 4'b0100, 0, 0, 0,     0};
        tbl[1]  = '{4'b1001, DPAT,         0, 0, 4'b1000, 1, 2, 'hAA, 0};
        tbl[2]  = '{4'b1001, DPAT,         0, 0, 4'b0001, 2, 2, 'hAA, 0};
        tbl[3]  = '{4'b0000, DPAT,         1, 0, 4'b0000, 3, 2, 'hAA, 0};
        tbl[4]  = '{4'b0000, DPAT,         0, 0, 4'b0000, 2, 3, 'h43, 0};
        tbl[5]  = '{4'b0000, DPAT,         1, 0, 4'b0000, 2, 3, 'h43, 0};
        tbl[6]  = '{4'b0010, DPAT,         1, 0, 4'b0010, 1, 0, 'h10, 0};
        tbl[7]  = '{4'b0000, DPAT,         0, 0, 4'b0000, 1, 1, 'h21, 0};
        tbl[8]  = '{4'b0000, DPAT,         1, 0, 4'b0000, 1, 1, 'h21, 0};
        tbl[9]  = '{4'b0000, DPAT,         1, 0, 4'b0000, 0, 0, 0,     0};
        tbl[10] = '{4'b1111, DPAT,         0, 1, 4'b0000, 0, 0, 0,     1};
        tbl[11] = '{4'b1111, DPAT,         0, 0, 4'b0100, 0, 0, 0,     1};
        tbl[12] = '{4'b0000, DPAT,         0, 0, 4'b0000, 1, 2, 'h32, 1};

        rst = 1'b1; ch_valid = '0; ch_data = '0; i_pop = 1'b0; i_flush = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Hand-computed vectors: round-robin restart point, FWFT head, pop_err stickiness, flush.
        for (int i = 0; i < 13; i++) begin
            drive_and_check(tbl[i].v, tbl[i].d, tbl[i].pop, tbl[i].fl);
            chk("tbl_ready", ch_ready, tbl[i].exp_ready);
            chk("tbl_level", o_level, tbl[i].exp_level);
            chk("tbl_err", pop_err, tbl[i].exp_err);
            if (tbl[i].exp_level > 0) begin
                chk("tbl_chan", o_chan, tbl[i].exp_chan);
                chk("tbl_data", o_data, tbl[i].exp_data);
            end
            commit();
        end

        // Fill from all channels: strict 0,1,2,3 rotation until full.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive_and_check('1, DPAT, 0, 0);
            chk("fill_order", ch_ready, 4'b0001 << (i % NCH));
            commit();
        end
        drive_and_check('1, DPAT, 0, 0);
        chk("fill_full", o_full, 1);
        chk("fill_level", o_level, 16);
        chk("fill_ready", ch_ready, 0);
        chk("fill_cnt", ch_count, 32'h04040404);
        chk("fill_chan", o_chan, 0);
        chk("fill_data", o_data, 8'h10);
        commit();

        // Full with simultaneous pop: the pop proceeds, the push waits a cycle.
        drive_and_check(4'b0010, DPAT, 1, 0);
        chk("fullpop_ready", ch_ready, 0);
        commit();
        chk("fullpop_level", o_level, 15);
        drive_and_check(4'b0010, DPAT, 0, 0);
        chk("refill_ready", ch_ready, 4'b0010);
        commit();
        chk("refill_level", o_level, 16);

        // Flush at level 9 keeps counters and drops the in-flight request.
        do_reset();
        repeat (9) step(4'b0001, DPAT, 0, 0);
        chk("pre_flush_level", o_level, 9);
        step(4'b0001, DPAT, 0, 1);
        chk("flush_level", o_level, 0);
        chk("flush_empty", o_empty, 1);
        chk("flush_cnt0", ch_count[CNTW-1:0], 9);

        // Counter saturation on one channel.
        do_reset();
        for (int i = 0; i < CMAX + 15; i++) step(4'b0010, DPAT, q.size() > 0, 0);
        chk("sat_cnt1", ch_count[CNTW +: CNTW], CMAX);

`ifdef MCAF_AFULL_EN
        do_reset();
        repeat (AF) step(4'b0001, DPAT, 0, 0);
        chk("af_lag", o_afull, 0);
        step('0, DPAT, 0, 0);
        chk("af_rise", o_afull, 1);
        step('0, DPAT, 1, 0);
        chk("af_hold", o_afull, 1);
        step('0, DPAT, 0, 0);
        chk("af_fall", o_afull, 0);
`endif

        // Random traffic with alternating fill/drain bias, rare flushes and resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic pop_b, fl_b;
            if ($urandom_range(0, 299) == 0) do_reset();
            fl_b  = ($urandom_range(0, 39) == 0);
            pop_b = ((cyc / 100) % 2 == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            if (fl_b) pop_b = 1'b0;
            step(NCH'($urandom), $urandom, pop_b, fl_b);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
